// File: rtl/scan_ctrl4.sv
// Scan controller for a 4-digit multiplexed display: walks the decoder select
// through four slots with a blank gap, frame-coherent snapshots and leading-zero blanking.
module scan_ctrl4 #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [15:0] i_data,
  input  logic        i_lzb,
  output logic [1:0]  o_sel,
  output logic        o_en,
  output logic [3:0]  o_digit,
  output logic        o_frame
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_sel;
  logic [15:0] r_snap;
  logic        r_lzb_q;
  logic [1:0]  r_o_sel;
  logic        r_o_en;
  logic [3:0]  r_o_digit;
  logic        r_o_frame;

  state_t      w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]  w_sel_nxt;
  logic [15:0] w_snap_nxt;
  logic        w_lzb_nxt;
  logic [1:0]  w_o_sel_nxt;
  logic        w_o_en_nxt;
  logic [3:0]  w_o_digit_nxt;
  logic        w_o_frame_nxt;

  // Slot k is blanked when it and every more-significant nibble are zero.
  function automatic logic slot_blanked(input logic [15:0] snap, input logic lzb,
                                        input logic [1:0] k);
    logic zero_above;
    case (k)
      2'd1:    zero_above = (snap[15:4] == 12'd0);
      2'd2:    zero_above = (snap[15:8] == 8'd0);
      2'd3:    zero_above = (snap[15:12] == 4'd0);
      default: zero_above = 1'b0;
    endcase
    return lzb && zero_above;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= 2'd0;
      r_snap    <= 16'd0;
      r_lzb_q   <= 1'b0;
      r_o_sel   <= 2'd0;
      r_o_en    <= 1'b0;
      r_o_digit <= 4'd0;
      r_o_frame <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_snap    <= w_snap_nxt;
      r_lzb_q   <= w_lzb_nxt;
      r_o_sel   <= w_o_sel_nxt;
      r_o_en    <= w_o_en_nxt;
      r_o_digit <= w_o_digit_nxt;
      r_o_frame <= w_o_frame_nxt;
    end
  end

  // Outputs are registered copies of the decode of next state, so they track state with no extra lag.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_snap_nxt    = r_snap;
    w_lzb_nxt     = r_lzb_q;
    w_o_sel_nxt   = 2'd0;
    w_o_en_nxt    = 1'b0;
    w_o_digit_nxt = 4'd0;
    w_o_frame_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_run) begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
          w_snap_nxt  = i_data;
          w_lzb_nxt   = i_lzb;
        end
      end
      SCAN: begin
        if (!i_run) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 2'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          w_sel_nxt = r_sel + 2'd1;
          if (r_sel == 2'd3) begin
            w_snap_nxt = i_data;
            w_lzb_nxt  = i_lzb;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_o_digit_nxt = w_snap_nxt[{w_sel_nxt, 2'b00} +: 4];
    if (w_state_nxt == SCAN) begin
      w_o_sel_nxt   = w_sel_nxt;
      w_o_frame_nxt = (w_sel_nxt == 2'd0) && (w_cnt_nxt == '0);
      w_o_en_nxt    = (32'(w_cnt_nxt) >= BLANK) &&
                      !slot_blanked(w_snap_nxt, w_lzb_nxt, w_sel_nxt);
    end
  end

  assign o_sel   = r_o_sel;
  assign o_en    = r_o_en;
  assign o_digit = r_o_digit;
  assign o_frame = r_o_frame;

endmodule

// File: tb/tb_scan_ctrl4.sv
// Bench for scan_ctrl4: three parameterisations driven in lockstep, checked against
// a time-index model of the scan (slot = t/DIV, frame = t/(4*DIV)).
module tb_scan_ctrl4;

  logic        clk = 1'b0;
  logic        i_rst, i_run, i_lzb;
  logic [15:0] i_data;

  logic [1:0] sel_w   [3];
  logic       en_w    [3];
  logic [3:0] digit_w [3];
  logic       frame_w [3];

  int unsigned divs   [3] = '{4, 2, 3};
  int unsigned blanks [3] = '{1, 0, 2};

  // model state
  logic        m_run  [3];
  int unsigned m_t    [3];
  logic [15:0] m_snap [3];
  logic        m_lzb  [3];
  logic        m_zero_known;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  scan_ctrl4 #(.DIV(4), .BLANK(1)) u_d0 (
    .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_data(i_data), .i_lzb(i_lzb),
    .o_sel(sel_w[0]), .o_en(en_w[0]), .o_digit(digit_w[0]), .o_frame(frame_w[0]));
  scan_ctrl4 #(.DIV(2), .BLANK(0)) u_d1 (
    .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_data(i_data), .i_lzb(i_lzb),
    .o_sel(sel_w[1]), .o_en(en_w[1]), .o_digit(digit_w[1]), .o_frame(frame_w[1]));
  scan_ctrl4 #(.DIV(3), .BLANK(2)) u_d2 (
    .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_data(i_data), .i_lzb(i_lzb),
    .o_sel(sel_w[2]), .o_en(en_w[2]), .o_digit(digit_w[2]), .o_frame(frame_w[2]));

  task automatic cmp(input string tag, input int d, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", tag, d, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic run, input logic [15:0] data,
                            input logic lzb);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_run[d] = 1'b0;
        m_snap[d] = 16'd0;
        m_zero_known = 1'b1;
      end else if (!m_run[d]) begin
        if (run) begin
          m_run[d] = 1'b1; m_t[d] = 0; m_snap[d] = data; m_lzb[d] = lzb;
          m_zero_known = 1'b0;
        end
      end else if (!run) begin
        m_run[d] = 1'b0;
      end else begin
        m_t[d]++;
        if (m_t[d] % (4 * divs[d]) == 0) begin
          m_snap[d] = data; m_lzb[d] = lzb;
        end
      end
    end
  endtask

  task automatic check_all();
    int unsigned slot, c;
    logic [15:0] upper;
    logic e_en;
    for (int d = 0; d < 3; d++) begin
      if (!m_run[d]) begin
        cmp("idle_sel", d, 4'(sel_w[d]), 4'd0);
        cmp("idle_en", d, 4'(en_w[d]), 4'd0);
        cmp("idle_frame", d, 4'(frame_w[d]), 4'd0);
        if (m_zero_known) cmp("rst_digit", d, digit_w[d], 4'd0);
      end else begin
        slot  = (m_t[d] / divs[d]) % 4;
        c     = m_t[d] % divs[d];
        upper = m_snap[d] >> (4 * slot);
        e_en  = (c >= blanks[d]) && !(m_lzb[d] && slot != 0 && upper == 16'd0);
        cmp("sel", d, 4'(sel_w[d]), 4'(slot));
        cmp("digit", d, digit_w[d], upper[3:0]);
        cmp("frame", d, 4'(frame_w[d]), 4'(m_t[d] % (4 * divs[d]) == 0));
        cmp("en", d, 4'(en_w[d]), 4'(e_en));
      end
    end
  endtask

  task automatic step(input logic rst, input logic run, input logic [15:0] data,
                      input logic lzb);
    @(negedge clk);
    i_rst = rst; i_run = run; i_data = data; i_lzb = lzb;
    @(posedge clk);
    model_edge(rst, run, data, lzb);
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    logic        r_run_s, r_lzb_s;
    logic [15:0] r_data_s;
    int          guard;
    i_rst = 1'b1; i_run = 1'b1; i_data = 16'h1234; i_lzb = 1'b0;
    m_zero_known = 1'b1;
    for (int d = 0; d < 3; d++) begin
      m_run[d] = 1'b0; m_t[d] = 0; m_snap[d] = 16'd0; m_lzb[d] = 1'b0;
    end

    // reset held with run high, then scan starts on first released edge
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    repeat (39) step(1'b0, 1'b1, 16'h1234, 1'b0);
    // mid-frame data change (dut0 is in slot 1 here)
    repeat (36) step(1'b0, 1'b1, 16'hABCD, 1'b0);
    // leading-zero blanking
    repeat (40) step(1'b0, 1'b1, 16'h0050, 1'b1);
    repeat (40) step(1'b0, 1'b1, 16'h0000, 1'b1);
    repeat (20) step(1'b0, 1'b1, 16'h1234, 1'b0);
    // abort when dut0 shows slot 2 cycle 2
    guard = 0;
    while (!(m_run[0] && m_t[0] % 16 == 10) && guard < 40) begin
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      guard++;
    end
    total++;
    assert (guard < 40) else begin
      bad++;
      $error("FAIL abort_align got=%0d exp=<40", guard);
    end
    repeat (3) step(1'b0, 1'b0, 16'h1234, 1'b0);
    repeat (20) step(1'b0, 1'b1, 16'h9876, 1'b0);
    // reset mid-scan, then idle until run returns
    step(1'b1, 1'b1, 16'h9876, 1'b0);
    repeat (2) step(1'b0, 1'b0, 16'h9876, 1'b0);
    repeat (10) step(1'b0, 1'b1, 16'h0700, 1'b1);

    // randomized phase
    r_run_s = 1'b1; r_lzb_s = 1'b0; r_data_s = 16'h1234;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(49) == 0) r_run_s = ~r_run_s;
      if ($urandom_range(19) == 0) r_lzb_s = ~r_lzb_s;
      if ($urandom_range(7) == 0) begin
        r_data_s = 16'($urandom);
        if ($urandom_range(1) == 0) r_data_s = r_data_s >> (4 * $urandom_range(3));
      end
      step(($urandom_range(199) == 0), r_run_s, r_data_s, r_lzb_s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
